// File: rtl/axi_to_mac_tx_buffer_if.sv
// AXI4-Lite write channel bundle between the interconnect and the TX buffer.
`timescale 1ns/1ps
interface axi_to_mac_tx_buffer_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID
    );
endinterface

// File: rtl/axi_to_mac_tx_buffer.sv
// Single-packet TX buffer: AXI4-Lite writes fill a RAM, a TX_LEN write
// launches streaming of the packet into the MAC user TX FIFO port.
`timescale 1ns/1ps
module axi_to_mac_tx_buffer #(
    parameter int _dat_w_mac         = 32,
    parameter int _ben_w_mac         = 2,
    parameter int _addr_w_mem        = 9,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                    mac_clk_i,
    input  logic                    ARESETN,
    axi_to_mac_tx_buffer_if.slave   s_axi,
    input  logic                    mac_txwa_i,
    output logic                    mac_txwr_o,
    output logic [_dat_w_mac-1:0]   mac_txd_o,
    output logic [_ben_w_mac-1:0]   mac_txben_o,
    output logic                    mac_txsop_o,
    output logic                    mac_txeop_o,
    output logic                    tx_busy_o,
    output logic [31:0]             pkt_count_o
);
    localparam int DEPTH = 1 << _addr_w_mem;
    localparam int BYTES = 4 * DEPTH;
    localparam int LW    = _addr_w_mem + 3;
    localparam int NW    = _addr_w_mem + 1;
    localparam int NB    = _dat_w_mac / 8;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] LEN_ADDR =
        C_S_AXI_ADDR_WIDTH'(BYTES);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

    state_e state_q, state_d;

    logic                      acc_q, bvalid_q, wbuf_q, wlen_q;
    logic [1:0]                bresp_q;
    logic [NW-1:0]             idx_q, n_q;
    logic [_ben_w_mac-1:0]     be_q;
    logic                      txwr_q, sop_q, eop_q;
    logic [_dat_w_mac-1:0]     txd_q;
    logic [_ben_w_mac-1:0]     ben_q;
    logic [31:0]               cnt_q;

    logic [_dat_w_mac-1:0]     mem [DEPTH];
    logic [_dat_w_mac-1:0]     ram_q;

    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic [_addr_w_mem-1:0]          waddr;
    logic [LW-1:0]                   len;
    logic [NW-1:0]                   len_words;
    logic                            busy, req, is_buf, is_len;
    logic                            len_ok, ok;
    logic                            adv, last, done;
    logic [NW-1:0]                   idx_n, n_m1;
    logic [_addr_w_mem-1:0]          raddr;

    assign awaddr    = s_axi.S_AXI_AWADDR;
    assign wdata     = s_axi.S_AXI_WDATA;
    assign wstrb     = s_axi.S_AXI_WSTRB;
    assign waddr     = awaddr[_addr_w_mem+1:2];
    assign len       = wdata[LW-1:0];
    assign len_words = len[LW-1:2] + NW'(|len[1:0]);

    assign busy   = (state_q != IDLE);
    assign req    = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q;
    assign is_buf = (awaddr < LEN_ADDR);
    assign is_len = (awaddr == LEN_ADDR);
    assign len_ok = (len != '0) && (len <= LW'(BYTES));
    assign ok     = ~busy & (is_buf | (is_len & len_ok));

    // Decision is taken in the request cycle and applied in the handshake
    // cycle, so a packet finishing in between cannot flip the response.
    always_ff @(posedge mac_clk_i) begin
        if (!ARESETN) begin
            acc_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
            wbuf_q   <= 1'b0;
            wlen_q   <= 1'b0;
        end else begin
            acc_q  <= req;
            wbuf_q <= req & ok & is_buf;
            wlen_q <= req & ok & is_len;
            if (req) begin
                bvalid_q <= 1'b1;
                bresp_q  <= ok ? OKAY : SLVERR;
            end else if (s_axi.S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = acc_q;
    assign s_axi.S_AXI_WREADY  = acc_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;

    always_ff @(posedge mac_clk_i) begin
        if (wbuf_q) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        ram_q <= mem[raddr];
    end

    // Read address follows the word that will be presented next; while
    // stalled the current word is simply re-read.
    always_comb begin
        adv   = (state_q == SEND) && mac_txwa_i && (idx_q != n_q);
        done  = (state_q == SEND) && (idx_q == n_q);
        idx_n = idx_q + NW'(1);
        n_m1  = n_q - NW'(1);
        last  = (idx_q == n_m1);
        raddr = adv ? idx_n[_addr_w_mem-1:0] : idx_q[_addr_w_mem-1:0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (wlen_q) state_d = LOAD;
            LOAD:    state_d = SEND;
            SEND:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mac_clk_i) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            be_q    <= '0;
            txwr_q  <= 1'b0;
            txd_q   <= '0;
            ben_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            txwr_q  <= adv;
            if (wlen_q && state_q == IDLE) begin
                idx_q <= '0;
                n_q   <= len_words;
                be_q  <= len[1:0] - 2'd1;
            end else if (adv) begin
                idx_q <= idx_n;
            end
            if (adv) begin
                txd_q <= ram_q;
                sop_q <= (idx_q == '0);
                eop_q <= last;
                ben_q <= last ? be_q : '1;
            end
            if (done) cnt_q <= cnt_q + 32'd1;
        end
    end

    assign mac_txwr_o  = txwr_q;
    assign mac_txd_o   = txd_q;
    assign mac_txben_o = ben_q;
    assign mac_txsop_o = sop_q;
    assign mac_txeop_o = eop_q;
    assign tx_busy_o   = busy;
    assign pkt_count_o = cnt_q;
endmodule

// File: tb/tb_axi_to_mac_tx_buffer.sv
// Directed bench for the AXI-Lite to MAC TX packet buffer.
`timescale 1ns/1ps
module tb_axi_to_mac_tx_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        txwa = 1'b0;
    logic        txwr, txsop, txeop, busy;
    logic [31:0] txd, cnt;
    logic [1:0]  txben;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int ncap = 0;
    int viol = 0;
    logic wa_prev = 1'b0;

    logic [31:0] cap_d   [64];
    logic        cap_sop [64];
    logic        cap_eop [64];
    logic [1:0]  cap_be  [64];
    int          cap_cyc [64];

    axi_to_mac_tx_buffer_if ax ();

    axi_to_mac_tx_buffer dut (
        .mac_clk_i   (clk),
        .ARESETN     (rst_n),
        .s_axi       (ax),
        .mac_txwa_i  (txwa),
        .mac_txwr_o  (txwr),
        .mac_txd_o   (txd),
        .mac_txben_o (txben),
        .mac_txsop_o (txsop),
        .mac_txeop_o (txeop),
        .tx_busy_o   (busy),
        .pkt_count_o (cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && txwr) begin
            if (!wa_prev) viol++;
            if (ncap < 64) begin
                cap_d[ncap]   = txd;
                cap_sop[ncap] = txsop;
                cap_eop[ncap] = txeop;
                cap_be[ncap]  = txben;
                cap_cyc[ncap] = cyc;
            end
            ncap++;
        end
        wa_prev = txwa;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expw(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] r);
        logic got;
        got = 1'b0;
        r = 2'bxx;
        ax.S_AXI_AWADDR  = a;
        ax.S_AXI_WDATA   = d;
        ax.S_AXI_WSTRB   = s;
        ax.S_AXI_AWVALID = 1'b1;
        ax.S_AXI_WVALID  = 1'b1;
        ax.S_AXI_BREADY  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ax.S_AXI_AWREADY) begin
                got = ax.S_AXI_WREADY & ax.S_AXI_BVALID;
                r = ax.S_AXI_BRESP;
                break;
            end
        end
        chk("handshake", {31'd0, got}, 32'd1);
        tick();
        ax.S_AXI_AWVALID = 1'b0;
        ax.S_AXI_WVALID  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            tick();
        end
        chk({tag, " done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_words(input string tag, input int n);
        for (int i = 0; i < 200; i++) begin
            if (ncap >= n) break;
            tick();
        end
        chk({tag, " reached"}, {31'd0, ncap >= n}, 32'd1);
    endtask

    task automatic chk_pkt(input string tag, input int nw,
                           input logic [1:0] lbe, input int c);
        int bad;
        logic lst;
        bad = 0;
        chk({tag, " words"}, ncap, nw);
        for (int i = 0; i < nw && i < 64; i++) begin
            lst = (i == nw - 1);
            if (cap_d[i] !== expw(i)) bad++;
            if (cap_sop[i] !== (i == 0)) bad++;
            if (cap_eop[i] !== lst) bad++;
            if (cap_be[i] !== (lst ? lbe : 2'b11)) bad++;
        end
        chk({tag, " fields"}, bad, 0);
        chk({tag, " cnt"}, cnt, c);
    endtask

    logic [1:0] r;
    int bad, n0;
    int lens [3] = '{61, 62, 63};
    logic [1:0] lbes [3] = '{2'b00, 2'b01, 2'b10};

    initial begin
        ax.S_AXI_AWADDR  = '0;
        ax.S_AXI_WDATA   = '0;
        ax.S_AXI_WSTRB   = '0;
        ax.S_AXI_AWVALID = 1'b0;
        ax.S_AXI_WVALID  = 1'b0;
        ax.S_AXI_BREADY  = 1'b0;
        repeat (3) tick();
        chk("rst awready", {31'd0, ax.S_AXI_AWREADY}, 0);
        chk("rst wready", {31'd0, ax.S_AXI_WREADY}, 0);
        chk("rst bvalid", {31'd0, ax.S_AXI_BVALID}, 0);
        chk("rst bresp", {30'd0, ax.S_AXI_BRESP}, 0);
        chk("rst mac", {txwr, txsop, txeop, txben}, 0);
        chk("rst txd", txd, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst cnt", cnt, 0);
        rst_n = 1'b1;
        tick();

        bad = 0;
        for (int i = 0; i < 16; i++) begin
            axi_wr(32'(4 * i), expw(i), 4'hF, r);
            if (r !== 2'b00) bad++;
        end
        chk("fill resp", bad, 0);

        txwa = 1'b1;
        ncap = 0;
        axi_wr(32'h800, 32'd64, 4'h0, r);
        chk("p64 resp", {30'd0, r}, 0);
        chk("p64 busy", {31'd0, busy}, 1);
        wait_idle("p64");
        chk_pkt("p64", 16, 2'b11, 1);
        chk("p64 span", cap_cyc[15] - cap_cyc[0], 15);

        for (int k = 0; k < 3; k++) begin
            ncap = 0;
            axi_wr(32'h800, 32'(lens[k]), 4'hF, r);
            chk("plen resp", {30'd0, r}, 0);
            wait_idle("plen");
            chk_pkt($sformatf("p%0d", lens[k]), 16, lbes[k], 2 + k);
        end

        ncap = 0;
        axi_wr(32'h800, 32'd3, 4'hF, r);
        wait_idle("p3");
        chk_pkt("p3", 1, 2'b10, 5);

        ncap = 0;
        axi_wr(32'h800, 32'd64, 4'hF, r);
        wait_words("stall", 5);
        txwa = 1'b0;
        n0 = ncap;
        repeat (5) tick();
        chk("stall extra", {31'd0, (ncap - n0) <= 1}, 1);
        chk("stall wr", {31'd0, txwr}, 0);
        chk("stall txd", txd, expw(ncap - 1));
        chk("stall eop", {31'd0, txeop}, 0);
        chk("stall busy", {31'd0, busy}, 1);
        txwa = 1'b1;
        wait_idle("stall");
        chk_pkt("stall", 16, 2'b11, 6);
        chk("wa viol", viol, 0);

        ncap = 0;
        axi_wr(32'h800, 32'd0, 4'hF, r);
        chk("len0 resp", {30'd0, r}, 32'd2);
        axi_wr(32'h800, 32'd2049, 4'hF, r);
        chk("len2049 resp", {30'd0, r}, 32'd2);
        axi_wr(32'h804, 32'd64, 4'hF, r);
        chk("a804 resp", {30'd0, r}, 32'd2);
        repeat (6) tick();
        chk("err words", ncap, 0);
        chk("err busy", {31'd0, busy}, 0);
        chk("err cnt", cnt, 6);

        txwa = 1'b0;
        ncap = 0;
        axi_wr(32'h800, 32'd64, 4'hF, r);
        chk("bz start", {30'd0, r}, 0);
        axi_wr(32'h0, 32'hDEADBEEF, 4'hF, r);
        chk("bz buf resp", {30'd0, r}, 32'd2);
        axi_wr(32'h800, 32'd8, 4'hF, r);
        chk("bz len resp", {30'd0, r}, 32'd2);
        txwa = 1'b1;
        wait_idle("bz");
        chk_pkt("bz", 16, 2'b11, 7);

        ncap = 0;
        axi_wr(32'h800, 32'd64, 4'hF, r);
        wait_words("rst mid", 7);
        rst_n = 1'b0;
        tick();
        chk("mid wr", {31'd0, txwr}, 0);
        chk("mid busy", {31'd0, busy}, 0);
        chk("mid cnt", cnt, 0);
        chk("mid txd", txd, 0);
        rst_n = 1'b1;
        tick();
        ncap = 0;
        axi_wr(32'h800, 32'd64, 4'hF, r);
        chk("resend resp", {30'd0, r}, 0);
        wait_idle("resend");
        chk_pkt("resend", 16, 2'b11, 1);

        axi_wr(32'h4, 32'hAABBCCDD, 4'b0101, r);
        chk("strb resp", {30'd0, r}, 0);
        ncap = 0;
        axi_wr(32'h800, 32'd8, 4'hF, r);
        wait_idle("strb");
        chk("strb words", ncap, 2);
        chk("strb w0", cap_d[0], expw(0));
        chk("strb w1", cap_d[1], 32'h04BB06DD);
        chk("strb be", {30'd0, cap_be[1]}, 32'd3);
        chk("strb cnt", cnt, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/axi_to_mac_tx_buffer.md
# axi_to_mac_tx_buffer

AXI4-Lite write slave that fills a single-packet transmit buffer and streams the committed packet into the tri-mode MAC user TX FIFO interface. Software writes payload words into the buffer, then writes the byte length to a control register to launch transmission. Sits between the processor AXI interconnect and the MAC TX user port, mirroring the RX packet buffer on the receive path.

## Interface
Parameters:
- `_dat_w_mac`, 32, MAC TX data width; only 32 supported.
- `_ben_w_mac`, 2, MAC TX byte-enable width; only 2 supported.
- `_addr_w_mem`, 9, buffer word-address width; 512 words, 2048 bytes.
- `C_S_AXI_ADDR_WIDTH`, 32, AXI address width.
- `C_S_AXI_DATA_WIDTH`, 32, AXI data width.

Ports:
- `mac_clk_i`  in  1  clock for both the AXI side and the MAC side.
- `ARESETN`  in  1  reset: synchronous, active-low, sampled on `mac_clk_i`.
- `S_AXI_AWADDR`  in  32  write byte address.
- `S_AXI_AWVALID` in 1 / `S_AXI_AWREADY` out 1: write-address handshake.
- `S_AXI_WDATA`  in  32  write data.
- `S_AXI_WSTRB`  in  4  byte strobes.
- `S_AXI_WVALID` in 1 / `S_AXI_WREADY` out 1: write-data handshake.
- `S_AXI_BRESP`  out  2  00 OKAY, 10 SLVERR.
- `S_AXI_BVALID` out 1 / `S_AXI_BREADY` in 1: response handshake.
- `mac_txwa_i`  in  1  MAC TX FIFO has space.
- `mac_txwr_o`  out  1  word write strobe to MAC.
- `mac_txd_o`  out  32  TX data.
- `mac_txben_o`  out  2  byte enable; meaningful on the eop word.
- `mac_txsop_o`  out  1  first word of the packet.
- `mac_txeop_o`  out  1  last word of the packet.
- `tx_busy_o`  out  1  high from commit until the eop word is written.
- `pkt_count_o`  out  32  count of packets fully sent; wraps.

## Operation
- Address map, decoded on AWADDR:
  - AWADDR < 4·2^_addr_w_mem selects buffer word AWADDR[_addr_w_mem+1:2].
  - AWADDR == 4·2^_addr_w_mem selects TX_LEN.
  - Any other address returns SLVERR with no effect.
- Buffer writes honour WSTRB per byte.
- TX_LEN write:
  - Takes WDATA[_addr_w_mem+2:0] as the byte length L, ignoring WSTRB.
  - Valid range is 1..4·2^_addr_w_mem.
  - L = 0 or an out-of-range L returns SLVERR and nothing starts.
  - A valid L returns OKAY and commits the packet.
- Any write while `tx_busy_o` = 1 returns SLVERR and is ignored, for both buffer and TX_LEN targets.
- TX FSM states:
  - IDLE: on commit, latch N = ceil(L/4) and the last-word BE code, then go to LOAD.
  - LOAD: issue the synchronous read of word 0 (1-cycle RAM latency), then go to SEND.
  - SEND: each accepted word advances the read pointer. After the eop word is written, increment `pkt_count_o` and go to IDLE.
- Byte-enable encoding on the eop word is set by L mod 4:
  - 1 → 00 (1 byte), 2 → 01, 3 → 10, 0 → 11 (4 bytes).
- Non-eop words drive `mac_txben_o` = 11.
- Single-word packet (L ≤ 4): sop and eop are asserted on the same word.
- Buffer contents persist after transmission, so rewriting only TX_LEN resends the same payload.

## Timing
- Reset values: all AXI READY/VALID = 0, BRESP = 00, `mac_txwr_o`/`mac_txsop_o`/`mac_txeop_o` = 0, `mac_txd_o` = 0, `mac_txben_o` = 00, `tx_busy_o` = 0, `pkt_count_o` = 0, FSM in IDLE.
- AXI write handshake:
  - Cycle k: AWVALID & WVALID & !BVALID.
  - Cycle k+1: AWREADY = WREADY = 1 as a single-cycle pulse, BVALID = 1, and the write takes effect at the end of this cycle.
  - BVALID holds until BREADY is sampled high.
  - No new write is accepted while BVALID = 1.
  - AW without W, or W without AW, waits.
- `tx_busy_o` rises in the cycle after the TX_LEN handshake cycle.
- First `mac_txwr_o` comes no earlier than 2 cycles after commit (LOAD plus RAM latency).
- `mac_txwr_o` is registered: it is high in cycle c only if `mac_txwa_i` was 1 at cycle c-1 and words remain. The MAC therefore receives at most one word after `mac_txwa_i` falls.
- While `mac_txwa_i` stays high, words are back-to-back, one per cycle. N words take N cycles.
- While stalled, `mac_txd_o`/`mac_txben_o`/sop/eop hold their values.
- On the eop word cycle `tx_busy_o` remains 1. It falls and `pkt_count_o` increments on the next cycle. `pkt_count_o` wraps 0xFFFFFFFF → 0.
- A commit accepted in the same cycle the previous packet finishes is impossible, because busy blocks it and returns SLVERR.
- ARESETN low mid-packet:
  - Next cycle all outputs return to reset values.
  - The packet is abandoned without eop, and the MAC discards the truncated frame.
  - `pkt_count_o` is cleared; buffer RAM is not cleared.

## Test plan
- Write 16 words 0x00010203… to addresses 0x00–0x3C, then TX_LEN = 64 with `mac_txwa_i` = 1 → 16 back-to-back writes, sop on word 0, eop + BE 11 on word 15, data matches, `pkt_count_o` = 1.
- TX_LEN = 61, 62, 63 → 16 words each, eop BE = 00, 01, 10 respectively; TX_LEN = 3 → single word with sop = eop = 1 and BE = 10.
- Toggle `mac_txwa_i` low for 5 cycles mid-packet → at most 1 word after the fall, outputs held, no words lost or duplicated, eop count correct.
- Write TX_LEN = 0, TX_LEN = 2049, and address 0x804 → BRESP = 10, no `mac_txwr_o`, `tx_busy_o` stays 0.
- Buffer write during transmission → BRESP = 10, transmitted data unchanged; WSTRB = 0101 on an idle write → only bytes 0 and 2 updated.
- Assert ARESETN low after word 7 of 16 → next cycle `mac_txwr_o` = 0, `tx_busy_o` = 0, `pkt_count_o` = 0; then TX_LEN = 64 → full packet resent from the retained buffer.
